// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide, one step per clock.
// Ports: clk, reset, start, op, a, b -> hi, lo, busy, ready, div_zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             ready,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic [CW-1:0]    cnt;
  // Operand that is not shifted: multiplicand or divisor magnitude.
  logic [WIDTH-1:0] mag_x;
  // MULT: {partial hi (W+1), multiplier/product lo (W)}.
  // DIV:  {remainder (W+1), dividend/quotient (W)}.
  logic [2*WIDTH:0] acc;

  logic             in_div;
  logic             in_sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             zero_div;

  always_comb begin
    in_div   = op[1];
    in_sgn   = ~op[0];
    a_neg    = in_sgn & a[WIDTH-1];
    b_neg    = in_sgn & b[WIDTH-1];
    // -MIN wraps to 2^(W-1), which is the correct unsigned magnitude.
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    zero_div = in_div & (b == '0);
  end

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [2*WIDTH:0] mul_next;
  logic [2*WIDTH:0] div_next;

  always_comb begin
    sum      = acc[2*WIDTH:WIDTH]
             + (acc[0] ? {1'b0, mag_x} : '0);
    mul_next = {1'b0, sum, acc[WIDTH-1:1]};
    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge       = trial >= {1'b0, mag_x};
    div_next = {ge ? trial - {1'b0, mag_x} : trial,
                acc[WIDTH-2:0], ge};
  end

  logic             neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  always_comb begin
    neg  = sign_a ^ sign_b;
    prod = acc[2*WIDTH-1:0];
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      // Truncation toward zero: remainder follows the dividend.
      fix_lo = neg ? -quo : quo;
      fix_hi = sign_a ? -rem : rem;
    end else begin
      prod   = neg ? -prod : prod;
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      cnt      <= '0;
      mag_x    <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            is_div <= in_div;
            sign_a <= a_neg;
            sign_b <= b_neg;
            cnt    <= '0;
            busy   <= 1'b1;
            if (in_div) begin
              mag_x <= b_mag;
              acc   <= {{(WIDTH+1){1'b0}}, a_mag};
            end else begin
              mag_x <= a_mag;
              acc   <= {{(WIDTH+1){1'b0}}, b_mag};
            end
            if (zero_div) begin
              state    <= DONE;
              hi       <= a;
              lo       <= '1;
              ready    <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          state <= DONE;
          hi    <= fix_hi;
          lo    <= fix_lo;
          ready <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          ready    <= 1'b0;
          div_zero <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit at WIDTH 32 and 8.
// Checks results, div_zero, latency, busy span, ignored start, reset abort.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start32;
  logic        start8;
  logic [1:0]  op;
  logic [31:0] a32;
  logic [31:0] b32;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [31:0] hi32;
  logic [31:0] lo32;
  logic [7:0]  hi8;
  logic [7:0]  lo8;
  logic        busy32;
  logic        busy8;
  logic        ready32;
  logic        ready8;
  logic        dz32;
  logic        dz8;

  int total;
  int bad;
  int rdy_cnt;
  bit sel8;

  muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start32), .op(op),
    .a(a32), .b(b32), .hi(hi32), .lo(lo32),
    .busy(busy32), .ready(ready32), .div_zero(dz32)
  );

  muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op),
    .a(a8), .b(b8), .hi(hi8), .lo(lo8),
    .busy(busy8), .ready(ready8), .div_zero(dz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ready32) rdy_cnt <= rdy_cnt + 1;
  end

  logic [31:0] hi_c;
  logic [31:0] lo_c;
  logic        busy_c;
  logic        ready_c;
  logic        dz_c;

  always_comb begin
    hi_c    = sel8 ? {24'b0, hi8} : hi32;
    lo_c    = sel8 ? {24'b0, lo8} : lo32;
    busy_c  = sel8 ? busy8 : busy32;
    ready_c = sel8 ? ready8 : ready32;
    dz_c    = sel8 ? dz8 : dz32;
  end

  typedef struct {
    bit          w8;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t tv[17];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Start on a negedge, scramble inputs after the start edge,
  // then count edges to ready and cycles with busy high.
  task automatic run(input vec_t v,
                     output logic [31:0] rhi,
                     output logic [31:0] rlo,
                     output logic rdz,
                     output int lat,
                     output int bcnt);
    int edges;
    bit seen;
    sel8 = v.w8;
    rhi = 'x; rlo = 'x; rdz = 1'bx;
    seen = 0;
    bcnt = 0;
    @(negedge clk);
    op = v.op;
    if (v.w8) begin
      a8 = v.a[7:0]; b8 = v.b[7:0]; start8 = 1'b1;
    end else begin
      a32 = v.a; b32 = v.b; start32 = 1'b1;
    end
    @(posedge clk);
    #1;
    edges = 1;
    start32 = 1'b0;
    start8 = 1'b0;
    op = ~v.op;
    a32 = $urandom; b32 = $urandom;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = -1;
    while (edges < 200) begin
      if (busy_c) bcnt++;
      if (ready_c && !seen) begin
        seen = 1;
        lat = edges;
        rhi = hi_c; rlo = lo_c; rdz = dz_c;
      end
      if (seen && !busy_c) break;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  initial begin
    logic [31:0] rhi;
    logic [31:0] rlo;
    logic        rdz;
    int          lat;
    int          bcnt;
    int          n;
    string       nm;

    total = 0; bad = 0; rdy_cnt = 0; sel8 = 0;
    start32 = 0; start8 = 0; op = 0;
    a32 = 0; b32 = 0; a8 = 0; b8 = 0;

    tv[0]  = '{0, 2'd0, 32'hFFFFFFFD, 32'd7,
               32'hFFFFFFFF, 32'hFFFFFFEB, 0, 34};
    tv[1]  = '{0, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 0, 34};
    tv[2]  = '{0, 2'd0, 32'h80000000, 32'h80000000,
               32'h40000000, 32'h0, 0, 34};
    tv[3]  = '{0, 2'd2, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34};
    tv[4]  = '{0, 2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 0, 34};
    tv[5]  = '{0, 2'd2, 32'h80000000, 32'hFFFFFFFF,
               32'h0, 32'h80000000, 0, 34};
    tv[6]  = '{0, 2'd3, 32'd5, 32'd0,
               32'd5, 32'hFFFFFFFF, 1, 1};
    tv[7]  = '{0, 2'd1, 32'd3, 32'd4, 32'd0, 32'hC, 0, 34};
    tv[8]  = '{0, 2'd2, 32'd100, 32'hFFFFFFF9,
               32'd2, 32'hFFFFFFF2, 0, 34};
    tv[9]  = '{0, 2'd1, 32'h10000, 32'h10000,
               32'd1, 32'd0, 0, 34};
    tv[10] = '{0, 2'd2, 32'hFFFFFFFB, 32'd0,
               32'hFFFFFFFB, 32'hFFFFFFFF, 1, 1};
    tv[11] = '{0, 2'd3, 32'hFFFFFFFF, 32'd10,
               32'd5, 32'h19999999, 0, 34};
    tv[12] = '{0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'd0, 32'd1, 0, 34};
    tv[13] = '{1, 2'd0, 32'hF0, 32'hF0, 32'h01, 32'h00, 0, 10};
    tv[14] = '{1, 2'd2, 32'h81, 32'h0A, 32'hF9, 32'hF4, 0, 10};
    tv[15] = '{1, 2'd3, 32'hFF, 32'h03, 32'h00, 32'h55, 0, 10};
    tv[16] = '{1, 2'd1, 32'hFF, 32'hFF, 32'hFE, 32'h01, 0, 10};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi32, 32'h0);
    chk("rst_lo", lo32, 32'h0);
    chk("rst_busy", {31'b0, busy32}, 32'h0);
    chk("rst_ready", {31'b0, ready32}, 32'h0);
    chk("rst_dz", {31'b0, dz32}, 32'h0);
    chk("rst_hi8", {24'b0, hi8}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run(tv[i], rhi, rlo, rdz, lat, bcnt);
      nm = $sformatf("v%0d", i);
      chk({nm, "_hi"}, rhi, tv[i].hi);
      chk({nm, "_lo"}, rlo, tv[i].lo);
      chk({nm, "_dz"}, {31'b0, rdz}, {31'b0, tv[i].dz});
      chk({nm, "_lat"}, 32'(lat), 32'(tv[i].lat));
      chk({nm, "_busy"}, 32'(bcnt), 32'(tv[i].lat));
    end

    // Start pulse while running MULT 3*4 must be ignored.
    sel8 = 0;
    @(negedge clk);
    op = 2'd0; a32 = 32'd3; b32 = 32'd4; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    op = 2'd3; a32 = 32'd5; b32 = 32'd0; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    n = 0;
    while (!ready32 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ign_ready", {31'b0, ready32}, 32'h1);
    chk("ign_hi", hi32, 32'h0);
    chk("ign_lo", lo32, 32'hC);
    chk("ign_dz", {31'b0, dz32}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_noqueue", {31'b0, busy32}, 32'h0);

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    op = 2'd1; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy_pre", {31'b0, busy32}, 32'h1);
    n = rdy_cnt;
    reset = 1'b1;
    #1;
    chk("abort_hi", hi32, 32'h0);
    chk("abort_lo", lo32, 32'h0);
    chk("abort_busy", {31'b0, busy32}, 32'h0);
    chk("abort_ready", {31'b0, ready32}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("abort_no_ready", 32'(rdy_cnt), 32'(n));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
